// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// The optional forced stall release is enabled by FIFO_ARB_STALL_RELEASE_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    // Width of a counter that must hold values 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin priority encoder: first asserted request at or
// above rr_ptr, searching upward with wrap at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               any
);

    int               idx;
    logic [PTR_W-1:0] idx_v;
    logic             found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = 0;
        idx_v    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr is always < NUM_REQ, so a single subtract is enough to wrap.
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = PTR_W'(idx);
            if (!found && req[idx_v]) begin
                found       = 1'b1;
                pick[idx_v] = 1'b1;
                pick_idx    = idx_v;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STALL_RELEASE_EN to release a grant after STALL_LIMIT full-stall cycles.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          full,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 || STALL_LIMIT < 1)
    begin : g_bad_param
        $error("fifo_wr_arb: parameter out of supported range");
    end

    arb_state_t                            state;
    logic [PTR_W-1:0]                      owner;
    logic [PTR_W-1:0]                      rr_ptr;
    logic [PTR_W-1:0]                      next_ptr;
    logic [CNT_W-1:0]                      burst_cnt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_word;
    logic [NUM_REQ-1:0]                    pick;
    logic [PTR_W-1:0]                      pick_idx;
    logic                                  pick_any;
    logic                                  in_burst;
    logic                                  owner_req;
    logic                                  last_word;
    logic                                  stall_hit;
    logic                                  burst_exit;

    assign req_word = req_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    assign in_burst  = (state == BURST);
    assign owner_req = req[owner];
    assign last_word = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign next_ptr  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // Write path is combinational off the registered grant so a write can land
    // in the same cycle full drops.
    always_comb begin
        wr     = in_burst & owner_req & ~full;
        ack    = wr ? grant : '0;
        w_data = in_burst ? req_word[owner] : '0;
    end

`ifdef FIFO_ARB_STALL_RELEASE_EN
    localparam int STALL_W = cnt_width(STALL_LIMIT - 1);

    logic [STALL_W-1:0] stall_cnt;

    assign stall_hit = in_burst & owner_req & full &
                       (stall_cnt == STALL_W'(STALL_LIMIT - 1));

    // Any write or exit breaks the run of consecutive stalls.
    always_ff @(posedge clk) begin
        if (reset || !in_burst || !(owner_req & full) || burst_exit) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_W'(STALL_LIMIT - 1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    assign burst_exit = in_burst & (~owner_req | (wr & last_word) | stall_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= BURST;
                        grant     <= pick;
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    if (burst_exit) begin
                        state     <= IDLE;
                        grant     <= '0;
                        burst_cnt <= '0;
                        rr_ptr    <= next_ptr;
                    end else if (wr) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: directed scenarios plus random traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int SL = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic            full;
    logic            wr;
    logic [DW-1:0]   w_data;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (DW),
        .MAX_BURST   (MB),
        .STALL_LIMIT (SL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .ack      (ack),
        .full     (full),
        .wr       (wr),
        .w_data   (w_data)
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic [N-1:0]  ack;
        logic          wr;
        logic [DW-1:0] w_data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int vectors     = 0;
    int miscompares = 0;
    int wr_seen     = 0;

    // Reference model: owner index (-1 when nobody holds the port), words
    // written in the current burst, consecutive stall cycles, next start point.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    int            m_stall = 0;
    logic [DW-1:0] word [N];
    logic [N-1:0]  exp_ack_prev = '0;
    bit            rnd_data = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic void release_owner();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endfunction

    // Advance the model by one clock edge using the inputs of the cycle just ended.
    function automatic void model_step();
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (req[i]) begin
                    m_owner = i;
                    m_cnt   = 0;
                    m_stall = 0;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            release_owner();
        end else if (!full) begin
            m_cnt++;
            m_stall = 0;
            if (m_cnt == MB) release_owner();
        end else begin
`ifdef FIFO_ARB_STALL_RELEASE_EN
            m_stall++;
            if (m_stall == SL) release_owner();
`endif
        end
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.grant  = '0;
        e.wr     = 1'b0;
        e.w_data = '0;
        if (m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.wr     = req[m_owner] && !full;
            e.w_data = word[m_owner];
        end
        e.ack = e.wr ? e.grant : '0;
        return e;
    endfunction

    task automatic cycle(input logic [N-1:0] r, input logic f, input logic rst);
        exp_t e;
        @(posedge clk);
        model_step();
        // A requester moves to its next word only after the model says it was acked.
        for (int i = 0; i < N; i++)
            if (exp_ack_prev[i]) word[i] = rnd_data ? DW'($urandom) : word[i] + 8'd1;
        #1;
        req   = r;
        full  = f;
        reset = rst;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word[i];
        e = expect_now();
        exp_ack_prev = e.ack;
        exp_q.push_back(e);
    endtask

    task automatic sync_count();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("grant",  32'(grant),  32'(mon_e.grant));
            check("wr",     32'(wr),     32'(mon_e.wr));
            check("ack",    32'(ack),    32'(mon_e.ack));
            check("w_data", 32'(w_data), 32'(mon_e.w_data));
            if (wr) wr_seen++;
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        full     = 1'b0;
        for (int i = 0; i < N; i++) word[i] = 8'hA0 + 8'(i * 16);
        req_data = '0;

        // Reset state, then a lone requester: four words, one idle cycle, regrant.
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        repeat (12) cycle(4'b0001, 1'b0, 1'b0);

        // Everyone requesting: bursts of four, 20 writes in 25 cycles.
        cycle(4'b0000, 1'b0, 1'b1);
        sync_count();
        wr_seen = 0;
        repeat (25) cycle(4'b1111, 1'b0, 1'b0);
        sync_count();
        check("writes_in_25_cycles", 32'(wr_seen), 32'd20);

        // Owner 2 stalls on full for five cycles mid-burst; exactly four words land.
        cycle(4'b0000, 1'b0, 1'b1);
        sync_count();
        wr_seen = 0;
        cycle(4'b0100, 1'b0, 1'b0);
        repeat (2) cycle(4'b0100, 1'b0, 1'b0);
        repeat (5) cycle(4'b0100, 1'b1, 1'b0);
        repeat (3) cycle(4'b0100, 1'b0, 1'b0);
        sync_count();
        check("writes_across_stall", 32'(wr_seen), 32'd4);

        // Owner 1 drops after two words; next grant goes to 2, skipping 0.
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        repeat (2) cycle(4'b1111, 1'b0, 1'b0);
        repeat (4) cycle(4'b1101, 1'b0, 1'b0);

        // Reset during requester 3's burst; first grant afterwards is requester 0.
        cycle(4'b0000, 1'b0, 1'b1);
        repeat (3) cycle(4'b1000, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b1);
        repeat (4) cycle(4'b1111, 1'b0, 1'b0);

        // Long full with two requesters (forced release only when enabled).
        cycle(4'b0000, 1'b0, 1'b1);
        repeat (22) cycle(4'b0011, 1'b1, 1'b0);
        repeat (6) cycle(4'b0011, 1'b0, 1'b0);

        // Random traffic with occasional resets and varying full pressure.
        rnd_data = 1'b1;
        for (int blk = 0; blk < 30; blk++) begin
            int full_pct = $urandom_range(0, 80);
            repeat (100) begin
                logic [N-1:0] r;
                for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) != 0);
                cycle(r, ($urandom_range(0, 99) < full_pct), ($urandom_range(0, 199) == 0));
            end
        end

        sync_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter sharing one FIFO write port among `NUM_REQ` producers. Sits in front of `fifo_ctrl` plus its register file. It grants one requester at a time for a bounded burst, muxes that requester's data onto the FIFO write bus, and gates writes against `full`. The block drives `wr` and `w_data`; `full` comes back from the FIFO controller.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: max words per grant, 1..15.
- `STALL_LIMIT`, 8: consecutive full-stall cycles before forced release; used only with the macro.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester write request, level; one word offered per cycle while high.
- `req_data`  in  NUM_REQ×DATA_WIDTH  packed per-requester data; index i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant`  out  NUM_REQ  one-hot (or zero) registered grant.
- `ack`  out  NUM_REQ  one-hot; word from requester i accepted this cycle.
- `full`  in  1  FIFO full flag.
- `wr`  out  1  FIFO write strobe.
- `w_data`  out  DATA_WIDTH  FIFO write data.

## Operation
- States: `IDLE`, `BURST`.
- IDLE:
  - If any `req`, choose the winner by round-robin starting at `rr_ptr`, searching upward with wrap.
  - Register `grant` one-hot and `owner`, clear `burst_cnt`, go to BURST.
  - If no `req`, stay in IDLE.
- BURST:
  - `wr = req[owner] & ~full`, combinational from registered grant.
  - `ack[owner] = wr`.
  - `w_data = req_data[owner]` at all times in BURST.
  - Each write increments `burst_cnt`.
- BURST exits to IDLE, clearing `grant`, when any of these holds:
  - `req[owner]` is low.
  - A write occurs with `burst_cnt == MAX_BURST-1`.
  - The forced-release condition occurs (macro enabled only).
- On exit, `rr_ptr <= (owner+1) mod NUM_REQ`.
- Full: no write, `burst_cnt` holds, grant held. The requester keeps its data stable and retries.
- Requester rule: a word is consumed only on `ack`; the requester must hold `req_data` until acked.
- Outside BURST: `wr=0`, `ack=0`, `w_data=0`.
- `burst_cnt` width is $clog2(MAX_BURST+1).
- `rr_ptr` width is $clog2(NUM_REQ) and wraps at NUM_REQ, not at a power of two.

## Timing
- Reset values: state IDLE, `grant=0`, `rr_ptr=0`, `burst_cnt=0`. Outputs `wr=0`, `ack=0`, `w_data=0`.
- Reset asserted mid-burst returns all state to reset values on the next edge. Any write in the reset cycle is the FIFO's concern.
- Latency: `req` rises in cycle n (IDLE) → `grant` in n+1 → first `wr` in n+1 if not full.
- One IDLE cycle always separates consecutive bursts, including back-to-back bursts by the same requester.
- Sustained throughput: MAX_BURST words per MAX_BURST+1 cycles.
- `req[owner]` dropping in BURST: no write that cycle; IDLE the next cycle.
- `full` deasserting: write in the same cycle `full` is low.

## Configuration
- `FIFO_ARB_STALL_RELEASE_EN` defined:
  - A saturating counter counts consecutive BURST cycles with `req[owner] & full`; any write or exit clears it.
  - When the counter reaches STALL_LIMIT-1 while still stalled, BURST exits to IDLE and `rr_ptr` advances, so other requesters get a turn.
- Undefined: no counter. The grant is held indefinitely while full, and STALL_LIMIT is ignored.

## Structure
- Package `fifo_arb_pkg`: `typedef enum logic {IDLE, BURST} arb_state_t`.
- Sub-module `rr_pick`:
  - Combinational round-robin priority encoder.
  - Inputs: `req`, `rr_ptr`. Outputs: one-hot `pick`, index `pick_idx`, `any`.
  - Parameterised by NUM_REQ.

## Test plan
- Single requester: `req=0001`, data 0xA0.. changing on each ack, full=0 → grant in cycle 1; 4 writes 0xA0–0xA3; 1 idle cycle; grant again.
- All four requesting continuously from reset → bursts of 4 in order 0,1,2,3,0; 20 writes in 25 cycles.
- Full stall: owner 2 mid-burst, full high 5 cycles → wr=0, grant held, burst_cnt frozen; full low → remaining words written, none lost or duplicated.
- Early drop: owner 1 drops req after 2 writes → IDLE next cycle; next grant goes to requester 2 even though 0 is requesting.
- Sync reset asserted during burst of requester 3 → grant=0, wr=0 after the edge; first post-reset grant goes to requester 0.
- Macro on, STALL_LIMIT=8: full held 20 cycles with req=0011 → owner 0 released after 8 stall cycles; requester 1 granted 2 cycles later.
